dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer placed in front of the data memory. Requester 0 is the core load/store unit; requester 1 is the debug/DMA port.
- Accepts one request at a time over a valid/ready handshake, drives the memory's addr/din/memOp/we for exactly one access cycle, then returns a response to the owning requester.
- The memory has a registered read (data is captured at the clock edge) and a same-edge write with byte mask derived from memOp and addr[1:0]. Its clkRd and clkWr are both tied to clk.

Parameters:
- addrWidth, 32, address width of requests and of the memory port.
- dataWidth, 32, data width of write data, read data and the memory port.

Ports:
- clk  input  1  single clock; also drives the memory's clkRd and clkWr.
- rstn  input  1  reset, asynchronous, active-low.
- reqValid0 / reqValid1  input  1  request present.
- reqReady0 / reqReady1  output  1  request accepted this cycle.
- reqAddr0 / reqAddr1  input  addrWidth  byte address.
- reqWdata0 / reqWdata1  input  dataWidth  store data, low-aligned.
- reqOp0 / reqOp1  input  3  memOp encoding: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- reqWe0 / reqWe1  input  1  1 = store, 0 = load.
- rspValid0 / rspValid1  output  1  response for that requester.
- rspReady0 / rspReady1  input  1  response consumed.
- rspRdata  output  dataWidth  load result, shared bus; 0 for stores.
- rspErr  output  1  access error, shared bus.
- mAddr  output  addrWidth  memory address.
- mDin  output  dataWidth  memory write data.
- mDout  input  dataWidth  memory read data (extended, offset-adjusted).
- mOp  output  3  memory memOp.
- mWe  output  1  memory write enable.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Async reset puts the FSM in IDLE.
- Reset values: all outputs 0; mAddr, mDin, mOp are 0 from the latch registers; lastGrant = 1, so requester 0 wins the first conflict.
- IDLE arbitration:
  - If exactly one reqValid is high, grant that requester.
  - If both are high, grant the requester that is not lastGrant (round-robin).
  - reqReadyN = (state==IDLE) & grant==N & reqValidN. This is combinational, and at most one ready is high.
  - On acceptance: latch addr, wdata, op, we and the owner into registers; update lastGrant; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mAddr, mDin, mOp are driven from the latches.
  - mWe = latched we.
  - The memory read or write takes effect at the closing edge. Go to RESP.
- RESP:
  - rspValid of the owner is high, held until its rspReady is high.
  - rspRdata = mDout for loads, 0 for stores.
  - mAddr and mOp stay held, so mDout remains stable while RESP waits.
  - On rspReady: go to IDLE. No new request is accepted in that same cycle.
- Timing: request accepted at edge N, rspValid high during cycle N+2. Minimum spacing is 3 cycles per access.
- mWe is never high outside ACCESS. Exactly one write occurs per accepted store.
- Back-pressure: a stalled rspReady holds the FSM in RESP indefinitely. The other requester waits; its reqReady stays low.
- Requester inputs are ignored outside IDLE, and may change freely after acceptance.
- Reset asserted mid-ACCESS before the edge: no write is issued and the FSM returns to IDLE. Reset in RESP drops the pending response.
- Address bits above the memory depth are passed through unchanged.

Optional Feature:
- Macro DMEM_ARB_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned request is one where op is H/HU and addr[0]=1, or op is W and addr[1:0]!=0.
  - A misaligned request is accepted normally, then skips ACCESS and goes directly to RESP.
  - mWe stays 0, and the response carries rspErr=1 with rspRdata=0.
- Undefined: rspErr is tied to 0 and every request is forwarded as-is.

Decomposition:
- Shared package dmem_pkg holds:
  - the memOp localparams (M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW);
  - the FSM state enum type;
  - an is_misaligned(op, addr[1:0]) function.
- One natural sub-module: dmem_rr_arb, a 2-way round-robin grant that takes valid[1:0] and lastGrant and produces grant[1:0].

Test Plan:
- Single store then load: r0 SW addr 0x100 data 0xDEADBEEF, then LW 0x100. Expect mWe high for exactly 1 cycle, then rspRdata=0xDEADBEEF at accept+2.
- Byte/sign paths: SB 0x103 data 0x80, then LB 0x103 gives 0xFFFFFF80 and LBU 0x103 gives 0x00000080. A word read of 0x100 afterwards shows the modified top byte only.
- Contention: both valid every cycle for 6 requests. Grants alternate r0, r1, r0, ...; first grant goes to r0 after reset.
- Back-pressure: rspReady0 held low for 5 cycles. rspValid0 and rspRdata are stable throughout, and reqReady1 stays 0 although reqValid1=1.
- Reset: deassert rstn while in ACCESS for a store to 0x200. The next LW 0x200 returns the prior value, and all outputs are 0 during reset.
- With DMEM_ARB_MISALIGN_CHECK_EN: SH 0x101 gives rspErr=1 at accept+1 and mWe never asserts. LW 0x102 also gives rspErr=1. LH 0x102 gives rspErr=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memOp codes, FSM state type
// and the alignment helper used by the optional misalignment check.
package dmem_pkg;

  localparam logic [2:0] M_LB  = 3'd0;
  localparam logic [2:0] M_LH  = 3'd1;
  localparam logic [2:0] M_LW  = 3'd2;
  localparam logic [2:0] M_LBU = 3'd4;
  localparam logic [2:0] M_LHU = 3'd5;
  localparam logic [2:0] M_SB  = 3'd0;
  localparam logic [2:0] M_SH  = 3'd1;
  localparam logic [2:0] M_SW  = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } dmem_state_t;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (op == M_LH || op == M_LHU) bad = a[0];
    else if (op == M_LW)           bad = (a != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin grant: a lone requester always wins, on a tie the
// requester that did not win last time is granted.
module dmem_rr_arb (
  input  logic [1:0] valid,
  input  logic       lastGrant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid == 2'b11) grant = lastGrant ? 2'b01 : 2'b10;
    else                grant = valid;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of the data memory (IDLE/ACCESS/RESP).
// Optional DMEM_ARB_MISALIGN_CHECK_EN rejects misaligned H/W accesses with rspErr.
module dmem_arbiter #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 reqValid0,
  input  logic                 reqValid1,
  output logic                 reqReady0,
  output logic                 reqReady1,
  input  logic [addrWidth-1:0] reqAddr0,
  input  logic [addrWidth-1:0] reqAddr1,
  input  logic [dataWidth-1:0] reqWdata0,
  input  logic [dataWidth-1:0] reqWdata1,
  input  logic [2:0]           reqOp0,
  input  logic [2:0]           reqOp1,
  input  logic                 reqWe0,
  input  logic                 reqWe1,
  output logic                 rspValid0,
  output logic                 rspValid1,
  input  logic                 rspReady0,
  input  logic                 rspReady1,
  output logic [dataWidth-1:0] rspRdata,
  output logic                 rspErr,
  output logic [addrWidth-1:0] mAddr,
  output logic [dataWidth-1:0] mDin,
  input  logic [dataWidth-1:0] mDout,
  output logic [2:0]           mOp,
  output logic                 mWe
);
  import dmem_pkg::*;

  dmem_state_t          state;
  logic                 lastGrant;
  logic                 owner;
  logic                 weQ;
  logic [1:0]           grant;
  logic                 sel;
  logic                 accept;
  logic                 selBad;
  logic [addrWidth-1:0] selAddr;
  logic [dataWidth-1:0] selWdata;
  logic [2:0]           selOp;
  logic                 selWe;
  logic                 rspDone;

  dmem_rr_arb u_arb (
    .valid     ({reqValid1, reqValid0}),
    .lastGrant (lastGrant),
    .grant     (grant)
  );

  // Ready is gated by rstn so every output reads 0 while reset is held.
  assign reqReady0 = rstn & (state == S_IDLE) & grant[0] & reqValid0;
  assign reqReady1 = rstn & (state == S_IDLE) & grant[1] & reqValid1;
  assign accept    = reqReady0 | reqReady1;
  assign sel       = grant[1];

  assign selAddr  = sel ? reqAddr1  : reqAddr0;
  assign selWdata = sel ? reqWdata1 : reqWdata0;
  assign selOp    = sel ? reqOp1    : reqOp0;
  assign selWe    = sel ? reqWe1    : reqWe0;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  assign selBad = is_misaligned(selOp, selAddr[1:0]);
`else
  assign selBad = 1'b0;
`endif

  assign rspDone  = owner ? rspReady1 : rspReady0;
  assign rspRdata = ((rspValid0 | rspValid1) && !weQ && !rspErr) ? mDout : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      lastGrant <= 1'b1;
      owner     <= 1'b0;
      weQ       <= 1'b0;
      mAddr     <= '0;
      mDin      <= '0;
      mOp       <= '0;
      mWe       <= 1'b0;
      rspValid0 <= 1'b0;
      rspValid1 <= 1'b0;
      rspErr    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mAddr     <= selAddr;
            mDin      <= selWdata;
            mOp       <= selOp;
            weQ       <= selWe;
            owner     <= sel;
            lastGrant <= sel;
            // A rejected access never reaches the memory: straight to RESP.
            if (selBad) begin
              state     <= S_RESP;
              rspErr    <= 1'b1;
              rspValid0 <= ~sel;
              rspValid1 <= sel;
            end else begin
              state  <= S_ACCESS;
              mWe    <= selWe;
              rspErr <= 1'b0;
            end
          end
        end
        S_ACCESS: begin
          mWe       <= 1'b0;
          state     <= S_RESP;
          rspValid0 <= ~owner;
          rspValid1 <= owner;
        end
        S_RESP: begin
          if (rspDone) begin
            state     <= S_IDLE;
            rspValid0 <= 1'b0;
            rspValid1 <= 1'b0;
            rspErr    <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          mWe   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural byte-masked memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        reqValid0 = 0, reqValid1 = 0;
  logic        reqReady0, reqReady1;
  logic [31:0] reqAddr0 = '0, reqAddr1 = '0;
  logic [31:0] reqWdata0 = '0, reqWdata1 = '0;
  logic [2:0]  reqOp0 = '0, reqOp1 = '0;
  logic        reqWe0 = 0, reqWe1 = 0;
  logic        rspValid0, rspValid1;
  logic        rspReady0 = 0, rspReady1 = 0;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic [31:0] mAddr, mDin, mDout;
  logic [2:0]  mOp;
  logic        mWe;

  int checks = 0;
  int failures = 0;
  int weCount = 0;

  logic [31:0] mem [0:255];
  logic [31:0] rdWord;

  dmem_arbiter #(.addrWidth(32), .dataWidth(32)) dut (
    .clk(clk), .rstn(rstn),
    .reqValid0(reqValid0), .reqValid1(reqValid1),
    .reqReady0(reqReady0), .reqReady1(reqReady1),
    .reqAddr0(reqAddr0), .reqAddr1(reqAddr1),
    .reqWdata0(reqWdata0), .reqWdata1(reqWdata1),
    .reqOp0(reqOp0), .reqOp1(reqOp1),
    .reqWe0(reqWe0), .reqWe1(reqWe1),
    .rspValid0(rspValid0), .rspValid1(rspValid1),
    .rspReady0(rspReady0), .rspReady1(rspReady1),
    .rspRdata(rspRdata), .rspErr(rspErr),
    .mAddr(mAddr), .mDin(mDin), .mDout(mDout), .mOp(mOp), .mWe(mWe)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] op, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    case (op)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mDout = '0;
  end

  assign rdWord = mem[mAddr[9:2]];

  always @(posedge clk) begin
    mDout <= ld_ext(rdWord, mOp, mAddr[1:0]);
    if (mWe) begin
      case (mOp[1:0])
        2'd0:    mem[mAddr[9:2]][8*mAddr[1:0] +: 8]  <= mDin[7:0];
        2'd1:    mem[mAddr[9:2]][16*mAddr[1] +: 16] <= mDin[15:0];
        default: mem[mAddr[9:2]] <= mDin;
      endcase
    end
  end

  always @(negedge clk) if (mWe) weCount++;

  task automatic send(input int r, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] op, input logic we);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    if (r == 0) begin reqValid0 = 1; reqAddr0 = a; reqWdata0 = d; reqOp0 = op; reqWe0 = we; end
    else        begin reqValid1 = 1; reqAddr1 = a; reqWdata1 = d; reqOp1 = op; reqWe1 = we; end
    while (!ok && n < 50) begin
      @(negedge clk);
      if ((r == 0 && reqReady0) || (r == 1 && reqReady1)) ok = 1;
      n++;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout r=%0d got=no_ready expected=ready", r);
    end else begin
      @(posedge clk); #1;
    end
    if (r == 0) reqValid0 = 0; else reqValid1 = 0;
  endtask

  task automatic take(input int r, output logic [31:0] rd, output logic err, output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if ((r == 0 && rspValid0) || (r == 1 && rspValid1)) got = 1;
    end
    rd  = rspRdata;
    err = rspErr;
    if (!got) begin
      checks++; failures++;
      $display("FAIL rsp_timeout r=%0d got=no_rspValid expected=rspValid", r);
    end
    if (r == 0) rspReady0 = 1; else rspReady1 = 1;
    @(posedge clk); #1;
    rspReady0 = 0;
    rspReady1 = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    reqValid0 = 1; reqValid1 = 1;
    repeat (3) @(negedge clk);
    outs = {reqReady0, reqReady1, rspValid0, rspValid1, rspErr, mWe, 26'd0};
    checks++;
    if (outs !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h expected=%h", outs, 32'd0); end
    checks++;
    if ((mAddr | mDin | rspRdata | {29'd0, mOp}) !== 32'd0) begin
      failures++; $display("FAIL reset_bus got=%h/%h/%h/%h expected=0", mAddr, mDin, rspRdata, mOp);
    end
    reqValid0 = 0; reqValid1 = 0;
    rstn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic err; int lat; int w0;
    w0 = weCount;
    send(0, 32'h100, 32'hDEADBEEF, 3'd2, 1'b1);
    checks++;
    if ({mWe, mOp, mAddr, mDin} !== {1'b1, 3'd2, 32'h100, 32'hDEADBEEF}) begin
      failures++; $display("FAIL sw_mem_port got=%b/%0d/%h/%h expected=1/2/00000100/deadbeef", mWe, mOp, mAddr, mDin);
    end
    take(0, rd, err, lat);
    checks++;
    if ({rd, err} !== {32'd0, 1'b0}) begin failures++; $display("FAIL sw_rsp got=%h/%b expected=00000000/0", rd, err); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d expected=2", lat); end
    checks++;
    if (weCount - w0 !== 1) begin failures++; $display("FAIL sw_we_cycles got=%0d expected=1", weCount - w0); end
    send(0, 32'h100, 32'h0, 3'd2, 1'b0);
    take(0, rd, err, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h expected=deadbeef", rd); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d expected=2", lat); end
    checks++;
    if (weCount - w0 !== 1) begin failures++; $display("FAIL lw_no_write got=%0d expected=1", weCount - w0); end
  endtask

  task automatic test_byte_sign();
    logic [31:0] rd; logic err; int lat;
    send(0, 32'h103, 32'h80, 3'd0, 1'b1);
    take(0, rd, err, lat);
    send(0, 32'h103, 32'h0, 3'd0, 1'b0);
    take(0, rd, err, lat);
    checks++;
    if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sign got=%h expected=ffffff80", rd); end
    send(0, 32'h103, 32'h0, 3'd4, 1'b0);
    take(0, rd, err, lat);
    checks++;
    if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu_zero got=%h expected=00000080", rd); end
    send(0, 32'h100, 32'h0, 3'd2, 1'b0);
    take(0, rd, err, lat);
    checks++;
    if (rd !== 32'h80ADBEEF) begin failures++; $display("FAIL lw_after_sb got=%h expected=80adbeef", rd); end
  endtask

  task automatic test_contention();
    int gr [6];
    int at [6];
    int cnt;
    int cyc;
    pulse_reset();
    reqAddr0 = 32'h100; reqOp0 = 3'd2; reqWe0 = 0;
    reqAddr1 = 32'h100; reqOp1 = 3'd4; reqWe1 = 0;
    reqValid0 = 1; reqValid1 = 1;
    rspReady0 = 1; rspReady1 = 1;
    cnt = 0;
    cyc = 0;
    while (cnt < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (reqReady0 && reqReady1) begin
        checks++; failures++; $display("FAIL both_ready got=11 expected=one_hot");
      end
      if (rspValid0) begin
        checks++;
        if (rspRdata !== 32'h80ADBEEF) begin failures++; $display("FAIL cont_r0_data got=%h expected=80adbeef", rspRdata); end
      end
      if (rspValid1) begin
        checks++;
        if (rspRdata !== 32'h000000EF) begin failures++; $display("FAIL cont_r1_data got=%h expected=000000ef", rspRdata); end
      end
      if (reqReady0 || reqReady1) begin
        gr[cnt] = reqReady1 ? 1 : 0;
        at[cnt] = cyc;
        cnt++;
      end
    end
    @(posedge clk); #1;
    reqValid0 = 0; reqValid1 = 0;
    repeat (3) @(posedge clk);
    #1;
    rspReady0 = 0; rspReady1 = 0;
    checks++;
    if (cnt !== 6) begin failures++; $display("FAIL cont_count got=%0d expected=6", cnt); end
    for (int i = 0; i < 6; i++) begin
      if (i < cnt) begin
        checks++;
        if (gr[i] !== (i % 2)) begin failures++; $display("FAIL cont_grant%0d got=%0d expected=%0d", i, gr[i], i % 2); end
        if (i > 0) begin
          checks++;
          if (at[i] - at[i-1] !== 3) begin failures++; $display("FAIL cont_spacing%0d got=%0d expected=3", i, at[i] - at[i-1]); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic err; int lat; int n;
    send(1, 32'h104, 32'h12345678, 3'd2, 1'b1);
    take(1, rd, err, lat);
    send(0, 32'h100, 32'h0, 3'd2, 1'b0);
    reqValid1 = 1; reqAddr1 = 32'h104; reqOp1 = 3'd2; reqWe1 = 0;
    n = 0;
    while (!rspValid0 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rspValid0, rspValid1, reqReady1, rspRdata} !== {3'b100, 32'h80ADBEEF}) begin
        failures++;
        $display("FAIL bp_hold%0d got=%b%b%b/%h expected=100/80adbeef", i, rspValid0, rspValid1, reqReady1, rspRdata);
      end
    end
    rspReady0 = 1;
    @(posedge clk); #1;
    rspReady0 = 0;
    send(1, 32'h104, 32'h0, 3'd2, 1'b0);
    take(1, rd, err, lat);
    checks++;
    if (rd !== 32'h12345678) begin failures++; $display("FAIL bp_r1_data got=%h expected=12345678", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int lat; int w0;
    send(0, 32'h200, 32'h11223344, 3'd2, 1'b1);
    take(0, rd, err, lat);
    w0 = weCount;
    send(0, 32'h200, 32'h55667788, 3'd2, 1'b1);
    rstn = 0;
    reqValid0 = 1;
    #1;
    checks++;
    if ({mWe, rspValid0, rspValid1, rspErr, reqReady0, reqReady1} !== 6'd0) begin
      failures++; $display("FAIL midrst_ctrl got=%b%b%b%b%b%b expected=000000", mWe, rspValid0, rspValid1, rspErr, reqReady0, reqReady1);
    end
    checks++;
    if ((mAddr | mDin | rspRdata | {29'd0, mOp}) !== 32'd0) begin
      failures++; $display("FAIL midrst_bus got=%h/%h/%h/%h expected=0", mAddr, mDin, rspRdata, mOp);
    end
    repeat (2) @(negedge clk);
    reqValid0 = 0;
    rstn = 1;
    @(posedge clk); #1;
    checks++;
    if (weCount - w0 !== 0) begin failures++; $display("FAIL midrst_no_write got=%0d expected=0", weCount - w0); end
    send(0, 32'h200, 32'h0, 3'd2, 1'b0);
    take(0, rd, err, lat);
    checks++;
    if (rd !== 32'h11223344) begin failures++; $display("FAIL midrst_lw got=%h expected=11223344", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic err; int lat; int w0;
    send(0, 32'h102, 32'h0, 3'd1, 1'b0);
    take(0, rd, err, lat);
    checks++;
    if ({rd, err} !== {32'hFFFF80AD, 1'b0}) begin failures++; $display("FAIL lh_aligned got=%h/%b expected=ffff80ad/0", rd, err); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL lh_latency got=%0d expected=2", lat); end
    w0 = weCount;
    send(0, 32'h101, 32'h1234, 3'd1, 1'b1);
    take(0, rd, err, lat);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    checks++;
    if ({rd, err, lat} !== {32'd0, 1'b1, 32'd1}) begin failures++; $display("FAIL sh_misalign got=%h/%b/%0d expected=00000000/1/1", rd, err, lat); end
    checks++;
    if (weCount - w0 !== 0) begin failures++; $display("FAIL sh_misalign_we got=%0d expected=0", weCount - w0); end
    send(1, 32'h102, 32'h0, 3'd2, 1'b0);
    take(1, rd, err, lat);
    checks++;
    if ({rd, err, lat} !== {32'd0, 1'b1, 32'd1}) begin failures++; $display("FAIL lw_misalign got=%h/%b/%0d expected=00000000/1/1", rd, err, lat); end
    send(0, 32'h100, 32'h0, 3'd2, 1'b0);
    take(0, rd, err, lat);
    checks++;
    if (rd !== 32'h80ADBEEF) begin failures++; $display("FAIL lw_unchanged got=%h expected=80adbeef", rd); end
`else
    checks++;
    if ({rd, err, lat} !== {32'd0, 1'b0, 32'd2}) begin failures++; $display("FAIL sh_forward got=%h/%b/%0d expected=00000000/0/2", rd, err, lat); end
    checks++;
    if (weCount - w0 !== 1) begin failures++; $display("FAIL sh_forward_we got=%0d expected=1", weCount - w0); end
    send(0, 32'h100, 32'h0, 3'd2, 1'b0);
    take(0, rd, err, lat);
    checks++;
    if ({rd, err} !== {32'h80AD1234, 1'b0}) begin failures++; $display("FAIL lw_after_sh got=%h/%b expected=80ad1234/0", rd, err); end
`endif
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_sign();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
